// File: rtl/bits_serial_logic_rx.sv
// bits_serial_logic_rx: bit-serial AND/OR/XOR/pass receiver assembling WIDTH-bit words (optional O_parity via SERIAL_LOGIC_RX_PARITY_EN)
module bits_serial_logic_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_i0,
  input  logic             in_i1,
  output logic [WIDTH-1:0] O,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_LOGIC_RX_PARITY_EN
  ,
  output logic             O_parity
`endif
);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op_q, op_eff;
  logic in_xfer, last, bit_v;
  always_comb begin
    in_ready = state == COLLECT;
    out_valid = state == HOLD;
    in_xfer = in_valid && in_ready;
    last = cnt == CNT_W'(WIDTH - 1);
    op_eff = cnt == '0 ? op : op_q;
    bit_v = op_eff == 2'b00 ? in_i0 & in_i1 :
            op_eff == 2'b01 ? in_i0 | in_i1 :
            op_eff == 2'b10 ? in_i0 ^ in_i1 : in_i0;
    state_nx = state;
    if (state == COLLECT && in_xfer && last) state_nx = HOLD;
    else if (state == HOLD && out_ready) state_nx = COLLECT;
  end
  always_ff @(posedge CLK or posedge ASYNCRESET)
    if (ASYNCRESET) state <= COLLECT;
    else state <= state_nx;
  always_ff @(posedge CLK or posedge ASYNCRESET)
    if (ASYNCRESET) begin
      cnt <= '0;
      op_q <= 2'b00;
      O <= '0;
    end else if (in_xfer) begin
      O <= (O & ~(WIDTH'(1) << cnt)) | (WIDTH'(bit_v) << cnt);
      cnt <= last ? '0 : cnt + CNT_W'(1);
      if (cnt == '0) op_q <= op;
    end
`ifdef SERIAL_LOGIC_RX_PARITY_EN
  always_ff @(posedge CLK or posedge ASYNCRESET)
    if (ASYNCRESET) O_parity <= 1'b0;
    else if (in_xfer) O_parity <= cnt == '0 ? bit_v : O_parity ^ bit_v;
`endif
endmodule

// File: tb/tb_bits_serial_logic_rx.sv
// tb_bits_serial_logic_rx: scoreboard bench for bits_serial_logic_rx (WIDTH=8 and WIDTH=1 instances)
module tb_bits_serial_logic_rx;
  logic CLK = 0;
  logic rst = 1;
  logic [1:0] op = 0, op1 = 0;
  logic in_valid = 0, i0 = 0, i1 = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [7:0] O;
  logic in_valid1 = 0, i01 = 0, i11 = 0, out_ready1 = 1;
  logic in_ready1, out_valid1;
  logic [0:0] O1;
`ifdef SERIAL_LOGIC_RX_PARITY_EN
  logic par, par1;
`endif
  logic [8:0] q[$];
  logic [1:0] q1[$];
  int n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  bits_serial_logic_rx #(.WIDTH(8)) dut (
    .CLK(CLK), .ASYNCRESET(rst), .op(op), .in_valid(in_valid), .in_ready(in_ready),
    .in_i0(i0), .in_i1(i1), .O(O), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SERIAL_LOGIC_RX_PARITY_EN
    , .O_parity(par)
`endif
  );
  bits_serial_logic_rx #(.WIDTH(1)) dut1 (
    .CLK(CLK), .ASYNCRESET(rst), .op(op1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_i0(i01), .in_i1(i11), .O(O1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef SERIAL_LOGIC_RX_PARITY_EN
    , .O_parity(par1)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK)
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("w8_unexpected_word", 32'(O), 32'hDEAD);
      else begin
        chk("w8_O", 32'(O), 32'(q[0][7:0]));
`ifdef SERIAL_LOGIC_RX_PARITY_EN
        chk("w8_parity", 32'(par), 32'(q[0][8]));
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
  always @(negedge CLK)
    if (!rst && out_valid1) begin
      if (q1.size() == 0) chk("w1_unexpected_word", 32'(O1), 32'hDEAD);
      else begin
        chk("w1_O", 32'(O1), 32'(q1[0][0]));
`ifdef SERIAL_LOGIC_RX_PARITY_EN
        chk("w1_parity", 32'(par1), 32'(q1[0][1]));
`endif
        if (out_ready1) void'(q1.pop_front());
      end
    end
  task automatic wait_rdy();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask
  task automatic send_bit(input logic [1:0] o, input logic a, input logic b);
    wait_rdy();
    op = o; i0 = a; i1 = b; in_valid = 1;
    @(posedge CLK); #1;
    in_valid = 0;
  endtask
  task automatic send_word(input logic [1:0] op0, input logic [1:0] opr, input logic [7:0] a,
                           input logic [7:0] b, input int gap_at, input int gap, input logic [7:0] exp);
    q.push_back({^exp, exp});
    for (int i = 0; i < 8; i++) begin
      send_bit(i == 0 ? op0 : opr, a[i], b[i]);
      if (i == gap_at)
        repeat (gap) begin
          @(posedge CLK); #1;
          chk("gap_no_valid", 32'(out_valid), 32'd0);
        end
    end
    chk("valid_latency", 32'(out_valid), 32'd1);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] pa, pb, pe;
    #2;
    chk("rst_O", 32'(O), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    rst = 0;
    send_word(2'b00, 2'b00, 8'hF0, 8'h3C, -1, 0, 8'h30);
    send_word(2'b01, 2'b01, 8'h81, 8'h42, 3, 3, 8'hC3);
    wait_rdy();
    out_ready = 0;
    send_word(2'b10, 2'b00, 8'hFF, 8'h0F, -1, 0, 8'hF0);
    repeat (5) begin
      @(posedge CLK); #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    @(posedge CLK); #1;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) send_bit(2'b00, 1'b1, 1'b1);
    #2 rst = 1;
    #1;
    chk("arst_O", 32'(O), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    rst = 0;
    send_word(2'b11, 2'b11, 8'h5A, 8'hFF, -1, 0, 8'h5A);
    send_word(2'b10, 2'b10, 8'h07, 8'h00, -1, 0, 8'h07);
    send_word(2'b10, 2'b10, 8'h03, 8'h00, -1, 0, 8'h03);
    pa = 3'b011; pb = 3'b101; pe = 3'b001;
    op1 = 2'b00;
    in_valid1 = 1;
    for (int i = 0; i < 3; i++) begin
      q1.push_back({pe[i], pe[i]});
      i01 = pa[i]; i11 = pb[i];
      @(posedge CLK); #1;
      chk("w1_valid", 32'(out_valid1), 32'd1);
      chk("w1_in_ready_hold", 32'(in_ready1), 32'd0);
      @(posedge CLK); #1;
      chk("w1_valid_low", 32'(out_valid1), 32'd0);
    end
    in_valid1 = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("queues_drained", 32'(q.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
